// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for an N-stage in-order pipeline: miss/hazard/redirect arbitration plus wait FSM and watchdog.
// Define PIPE_STALL_PERF_EN to add the saturating stall-cycle and flush-event counters.
module pipeline_stall_ctrl #(
    parameter int NSTAGES     = 5,
    parameter int ID_STAGE    = 1,
    parameter int REDIR_STAGE = 2,
    parameter int MEM_STAGE   = 3,
    parameter int MISS_TO     = 255,
    parameter int CNT_W       = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               i_imiss,
    input  logic               i_dmiss,
    input  logic               i_load_use,
    input  logic               i_redirect,
    output logic               o_pc_stall,
    output logic [NSTAGES-2:0] o_stall,
    output logic [NSTAGES-2:0] o_flush,
    output logic [1:0]         o_state,
    output logic               o_timeout
`ifdef PIPE_STALL_PERF_EN
   ,output logic [CNT_W-1:0]   o_stall_cycles,
    output logic [CNT_W-1:0]   o_flush_events
`endif
);

    localparam int WCNT_W = (MISS_TO < 1) ? 1 : $clog2(MISS_TO + 1);

    typedef enum logic [1:0] {RUN = 2'd0, IWAIT = 2'd1, DWAIT = 2'd2} state_t;

    generate
        if (NSTAGES < 4 || ID_STAGE < 1 || MEM_STAGE <= REDIR_STAGE ||
            MEM_STAGE > NSTAGES - 2 || MISS_TO < 1 || CNT_W < 1) begin : g_bad_params
            $error("pipeline_stall_ctrl: illegal parameter combination");
        end
    endgenerate

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              do_dmiss, do_redir, do_lu, do_imiss;
    logic              in_wait, wait_entry, cnt_sat;

    // One-hot winner of the priority chain; Rst gating zeroes the outputs during reset.
    assign do_dmiss = Rst & i_dmiss;
    assign do_redir = Rst & ~i_dmiss & i_redirect;
    assign do_lu    = Rst & ~i_dmiss & ~i_redirect & i_load_use;
    assign do_imiss = Rst & ~i_dmiss & ~i_redirect & ~i_load_use & i_imiss;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= RUN;
        else      state <= state_nxt;
    end

    // A redirect while the D-miss is held is masked by priority, so it waits for release.
    always_comb begin
        state_nxt = RUN;
        if (do_dmiss)      state_nxt = DWAIT;
        else if (do_imiss) state_nxt = IWAIT;
    end

    always_comb begin
        o_pc_stall = 1'b0;
        o_stall    = '0;
        o_flush    = '0;
        if (do_dmiss) begin
            o_pc_stall         = 1'b1;
            for (int k = 0; k < NSTAGES - 1; k++)
                if (k < MEM_STAGE) o_stall[k] = 1'b1;
            o_flush[MEM_STAGE] = 1'b1;
        end else if (do_redir) begin
            for (int k = 0; k < NSTAGES - 1; k++)
                if (k < REDIR_STAGE) o_flush[k] = 1'b1;
        end else if (do_lu) begin
            o_pc_stall        = 1'b1;
            for (int k = 0; k < NSTAGES - 1; k++)
                if (k < ID_STAGE) o_stall[k] = 1'b1;
            o_flush[ID_STAGE] = 1'b1;
        end else if (do_imiss) begin
            o_pc_stall = 1'b1;
            o_flush[0] = 1'b1;
        end
    end

    assign o_state = state;

    // Watchdog: restarts on every wait-state entry (including IWAIT->DWAIT), counts every wait cycle.
    assign in_wait    = (state != RUN);
    assign wait_entry = (state_nxt != RUN) && (state_nxt != state);
    assign cnt_sat    = (wait_cnt == WCNT_W'(MISS_TO));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wait_cnt  <= '0;
            o_timeout <= 1'b0;
        end else if (wait_entry) begin
            wait_cnt <= '0;
        end else if (in_wait && !cnt_sat) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WCNT_W'(MISS_TO - 1)) o_timeout <= 1'b1;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_stall_cycles <= '0;
            o_flush_events <= '0;
        end else begin
            if (o_pc_stall && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + 1'b1;
            if ((|o_flush) && !(&o_flush_events)) o_flush_events <= o_flush_events + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl (default parameters): vector table plus hand sequences, scoreboard-checked.
module tb_pipeline_stall_ctrl;

    localparam int CW = 32;
    localparam logic [3:0] R_0 = 4'b0000, R_I = 4'b0001, R_L = 4'b0010, R_R = 4'b0100, R_D = 4'b1000;
    localparam logic [1:0] S_RUN = 2'd0, S_IW = 2'd1, S_DW = 2'd2;

    logic       Clk = 1'b0, Rst = 1'b0;
    logic       imiss = 1'b0, dmiss = 1'b0, load_use = 1'b0, redirect = 1'b0;
    logic       pc_stall, timeout;
    logic [3:0] stall, flush;
    logic [1:0] state;
`ifdef PIPE_STALL_PERF_EN
    logic [CW-1:0] stall_cycles, flush_events;
`endif

    pipeline_stall_ctrl dut (
        .Clk(Clk), .Rst(Rst),
        .i_imiss(imiss), .i_dmiss(dmiss), .i_load_use(load_use), .i_redirect(redirect),
        .o_pc_stall(pc_stall), .o_stall(stall), .o_flush(flush),
        .o_state(state), .o_timeout(timeout)
`ifdef PIPE_STALL_PERF_EN
       ,.o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       pc;
        logic [3:0] stall;
        logic [3:0] flush;
        logic [1:0] st;
        logic       to;
        bit         to_chk;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] req;   // {dmiss, redirect, load_use, imiss}
        logic       pc;
        logic [3:0] stall;
        logic [3:0] flush;
        logic [1:0] nst;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic pc, input logic [3:0] s,
                                input logic [3:0] f, input logic [1:0] st, input logic to, input bit tc);
        exp_t e;
        e.name = n; e.pc = pc; e.stall = s; e.flush = f; e.st = st; e.to = to; e.to_chk = tc;
        return e;
    endfunction

    // Expected output patterns for each winning request (defaults: ID=1, EX=2, MA=3).
    function automatic exp_t e_d(input string n, input logic [1:0] st, input logic to);
        return mk(n, 1'b1, 4'b0111, 4'b1000, st, to, 1'b1);
    endfunction
    function automatic exp_t e_r(input string n, input logic [1:0] st, input logic to);
        return mk(n, 1'b0, 4'b0000, 4'b0011, st, to, 1'b1);
    endfunction
    function automatic exp_t e_l(input string n, input logic [1:0] st, input logic to);
        return mk(n, 1'b1, 4'b0001, 4'b0010, st, to, 1'b1);
    endfunction
    function automatic exp_t e_i(input string n, input logic [1:0] st, input logic to);
        return mk(n, 1'b1, 4'b0000, 4'b0001, st, to, 1'b1);
    endfunction
    function automatic exp_t e_0(input string n, input logic [1:0] st, input logic to);
        return mk(n, 1'b0, 4'b0000, 4'b0000, st, to, 1'b1);
    endfunction

    task automatic step(input logic [3:0] req, input exp_t e);
        @(posedge Clk);
        #1;
        {dmiss, redirect, load_use, imiss} = req;
        sb.push_back(e);
    endtask

    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, " pc_stall"}, 32'(pc_stall), 32'(e.pc));
            chk({e.name, " stall"},    32'(stall),    32'(e.stall));
            chk({e.name, " flush"},    32'(flush),    32'(e.flush));
            chk({e.name, " state"},    32'(state),    32'(e.st));
            if (e.to_chk) chk({e.name, " timeout"}, 32'(timeout), 32'(e.to));
        end
    end

    vec_t tbl[10];

    initial begin
        tbl[0] = '{"idle",        R_0,                   1'b0, 4'b0000, 4'b0000, S_RUN};
        tbl[1] = '{"dmiss",       R_D,                   1'b1, 4'b0111, 4'b1000, S_DW};
        tbl[2] = '{"redirect",    R_R,                   1'b0, 4'b0000, 4'b0011, S_RUN};
        tbl[3] = '{"load_use",    R_L,                   1'b1, 4'b0001, 4'b0010, S_RUN};
        tbl[4] = '{"imiss",       R_I,                   1'b1, 4'b0000, 4'b0001, S_IW};
        tbl[5] = '{"collision",   R_I | R_L | R_R,       1'b0, 4'b0000, 4'b0011, S_RUN};
        tbl[6] = '{"all_req",     R_D | R_R | R_L | R_I, 1'b1, 4'b0111, 4'b1000, S_DW};
        tbl[7] = '{"lu_over_im",  R_L | R_I,             1'b1, 4'b0001, 4'b0010, S_RUN};
        tbl[8] = '{"red_over_im", R_R | R_I,             1'b0, 4'b0000, 4'b0011, S_RUN};
        tbl[9] = '{"dm_over_im",  R_D | R_I,             1'b1, 4'b0111, 4'b1000, S_DW};

        // Reset state with all inputs low.
        #2;
        chk("reset pc_stall", 32'(pc_stall), 0);
        chk("reset stall",    32'(stall),    0);
        chk("reset flush",    32'(flush),    0);
        chk("reset state",    32'(state),    0);
        chk("reset timeout",  32'(timeout),  0);
        @(negedge Clk);
        Rst = 1'b1;

        // Each vector from RUN, then a release cycle showing the next state, then back to RUN.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].req, mk(tbl[i].name, tbl[i].pc, tbl[i].stall, tbl[i].flush, S_RUN, 1'b0, 1'b1));
            step(R_0, e_0({tbl[i].name, " next"}, tbl[i].nst, 1'b0));
            step(R_0, e_0({tbl[i].name, " idle"}, S_RUN, 1'b0));
        end

        // D-miss held 4 cycles.
        step(R_D, e_d("dm4 c0", S_RUN, 1'b0));
        for (int i = 1; i < 4; i++) step(R_D, e_d("dm4 hold", S_DW, 1'b0));
        step(R_0, e_0("dm4 release", S_DW, 1'b0));
        step(R_0, e_0("dm4 run", S_RUN, 1'b0));

        // Nested miss: IWAIT -> DWAIT -> IWAIT, redirect aborts IWAIT, imiss drop releases.
        step(R_I,       e_i("nest im",        S_RUN, 1'b0));
        step(R_D | R_I, e_d("nest dm0",       S_IW,  1'b0));
        step(R_D | R_I, e_d("nest dm1",       S_DW,  1'b0));
        step(R_D | R_I, e_d("nest dm2",       S_DW,  1'b0));
        step(R_I,       e_i("nest release",   S_DW,  1'b0));
        step(R_I,       e_i("nest iwait",     S_IW,  1'b0));
        step(R_R | R_I, e_r("nest redirect",  S_IW,  1'b0));
        step(R_I,       e_i("nest im again",  S_RUN, 1'b0));
        step(R_0,       e_0("nest im drop",   S_IW,  1'b0));
        step(R_0,       e_0("nest run",       S_RUN, 1'b0));

        // Redirect held during DWAIT is serviced on the release cycle.
        step(R_D,       e_d("dw red c0",      S_RUN, 1'b0));
        step(R_D | R_R, e_d("dw red masked",  S_DW,  1'b0));
        step(R_R,       e_r("dw red release", S_DW,  1'b0));
        step(R_0,       e_0("dw red run",     S_RUN, 1'b0));

        // Load-use held two cycles stays in RUN; load-use in IWAIT returns to RUN.
        step(R_L,       e_l("lu c0",          S_RUN, 1'b0));
        step(R_L,       e_l("lu c1",          S_RUN, 1'b0));
        step(R_I,       e_i("iw lu im",       S_RUN, 1'b0));
        step(R_L | R_I, e_l("iw lu",          S_IW,  1'b0));
        step(R_I,       e_i("iw lu after",    S_RUN, 1'b0));
        step(R_0,       e_0("iw lu drop",     S_IW,  1'b0));
        step(R_0,       e_0("iw lu run",      S_RUN, 1'b0));

        // Watchdog: D-miss held far past MISS_TO; flag stays set after release.
        for (int i = 0; i < 256; i++)
            step(R_D, mk("wd hold", 1'b1, 4'b0111, 4'b1000, (i == 0) ? S_RUN : S_DW, 1'b0, i <= 250));
        step(R_0, mk("wd release", 1'b0, 4'b0000, 4'b0000, S_DW, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) step(R_0, e_0("wd sticky", S_RUN, 1'b1));
        step(R_I, e_i("wd im", S_RUN, 1'b1));
        step(R_0, e_0("wd im drop", S_IW, 1'b1));

        // Asynchronous reset in the middle of a D-miss wait.
        step(R_D, e_d("rst dm0", S_RUN, 1'b1));
        step(R_D, e_d("rst dm1", S_DW,  1'b1));
        @(negedge Clk);
        #1;
        Rst = 1'b0;
        #1;
        chk("async rst pc_stall", 32'(pc_stall), 0);
        chk("async rst stall",    32'(stall),    0);
        chk("async rst flush",    32'(flush),    0);
        chk("async rst state",    32'(state),    0);
        chk("async rst timeout",  32'(timeout),  0);
        @(posedge Clk);
        #1;
        chk("held rst state", 32'(state),    0);
        chk("held rst stall", 32'(pc_stall), 0);
        @(negedge Clk);
        dmiss = 1'b0;
        Rst   = 1'b1;

        // Resume from RUN: 4-cycle D-miss plus one load-use.
        step(R_0, e_0("post idle", S_RUN, 1'b0));
        step(R_D, e_d("post dm0", S_RUN, 1'b0));
        for (int i = 1; i < 4; i++) step(R_D, e_d("post dm", S_DW, 1'b0));
        step(R_0, e_0("post release", S_DW,  1'b0));
        step(R_L, e_l("post lu",      S_RUN, 1'b0));
        step(R_0, e_0("post idle2",   S_RUN, 1'b0));
        repeat (2) @(negedge Clk);
`ifdef PIPE_STALL_PERF_EN
        chk("perf stall_cycles", stall_cycles, 32'd5);
        chk("perf flush_events", flush_events, 32'd5);
`endif
        chk("scoreboard drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
